// File: rtl/flow_ram_pkg.sv
// -----------------------------------------------------------------------------
// flow_ram_pkg
// Shared defaults for the flow-table SRAM front end: SRAM word address width,
// SRAM word width, read-tag width, and a constant-evaluable ceil(log2) helper
// used to size FIFO pointers and occupancy counters.
// -----------------------------------------------------------------------------
package flow_ram_pkg;

  localparam int FLOW_RAM_ADDR_WIDTH = 19;
  localparam int FLOW_RAM_WORD_WIDTH = 72;
  localparam int FLOW_RAM_TAG_WIDTH  = 8;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/flow_ram_fifo.sv
// -----------------------------------------------------------------------------
// flow_ram_fifo
// Synchronous FIFO with show-ahead head output and asynchronous active-high
// reset. Pointers carry one extra bit so full and empty are distinguishable;
// occupancy is the pointer difference.
//
// Ports:
//   clk, reset      clock, async active-high reset (clears pointers and storage)
//   push_i, din_i   write an entry (ignored when full)
//   pop_i           retire the head entry (ignored when empty)
//   dout_o          current head entry (valid when !empty_o)
//   full_o, empty_o status from registered pointers only
//   count_o         registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module flow_ram_fifo
  import flow_ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   count_o
);

  // At least one index bit so a depth-1 FIFO still has a well-formed pointer.
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign occ     = wptr_q - rptr_q;
  assign full_o  = (occ == PW'(DEPTH));
  assign empty_o = (occ == '0);
  assign count_o = occ[CW-1:0];
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  // Storage is reset too so the head output is never X after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/flow_ram_sram_ctrl.sv
// -----------------------------------------------------------------------------
// flow_ram_sram_ctrl
// Buffered front end between the flow-table engine and the SRAM arbiter ports.
// Write and read requests are queued in small FIFOs; SRAM requests are held
// until acknowledged; acknowledged reads push their caller tag into a tag FIFO
// that bounds the reads in flight and labels each returning word.
//
// Ports:
//   clk, reset                          clock, async active-high reset
//   write_ready/en/addr/data            write request channel from flow engine
//   read_ready/en/addr/tag              read request channel from flow engine
//   read_data/_tag/_new                 returned word, its tag, valid strobe
//   read_underflow                      sticky: data returned with no read outstanding
//   wr_0_addr/data/req/ack              SRAM write port
//   rd_0_addr/req/ack/data/vld          SRAM read port
// -----------------------------------------------------------------------------
module flow_ram_sram_ctrl
  import flow_ram_pkg::*;
#(
  parameter int ADDR_WIDTH      = FLOW_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = FLOW_RAM_WORD_WIDTH,
  parameter int TAG_WIDTH       = FLOW_RAM_TAG_WIDTH,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // write request channel
  output logic                  write_ready,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  // read request channel
  output logic                  read_ready,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [TAG_WIDTH-1:0]  read_tag,
  // read return
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [TAG_WIDTH-1:0]  read_data_tag,
  output logic                  read_data_new,
  output logic                  read_underflow,
  // SRAM write port
  output logic [ADDR_WIDTH-1:0] wr_0_addr,
  output logic [DATA_WIDTH-1:0] wr_0_data,
  output logic                  wr_0_req,
  input  logic                  wr_0_ack,
  // SRAM read port
  output logic [ADDR_WIDTH-1:0] rd_0_addr,
  output logic                  rd_0_req,
  input  logic                  rd_0_ack,
  input  logic [DATA_WIDTH-1:0] rd_0_data,
  input  logic                  rd_0_vld
);

  localparam int WW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int RW  = ADDR_WIDTH + TAG_WIDTH;
  localparam int WCW = clog2(REQ_DEPTH) + 1;
  localparam int TCW = clog2(MAX_OUTSTANDING) + 1;

  logic [WW-1:0]        w_head;
  logic                 w_full, w_empty;
  logic [WCW-1:0]       w_count;
  logic [RW-1:0]        r_head;
  logic                 r_full, r_empty;
  logic [WCW-1:0]       r_count;
  logic [TAG_WIDTH-1:0] t_head;
  logic                 t_full_flag, t_empty;
  logic [TCW-1:0]       t_count;
  logic                 tag_full;
  logic                 rd_issue;
  logic                 underflow_q, underflow_d;
  logic                 unused_status;

  // Write channel: FIFO head drives the SRAM port directly.
  flow_ram_fifo #(.WIDTH(WW), .DEPTH(REQ_DEPTH)) u_wfifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (write_en && write_ready),
    .din_i   ({write_addr, write_data}),
    .pop_i   (wr_0_req && wr_0_ack),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign write_ready = !w_full;
  assign wr_0_req    = !w_empty;
  assign wr_0_addr   = w_head[WW-1:DATA_WIDTH];
  assign wr_0_data   = w_head[DATA_WIDTH-1:0];

  // Read channel: a request is only presented while a tag slot is free.
  flow_ram_fifo #(.WIDTH(RW), .DEPTH(REQ_DEPTH)) u_rfifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (read_en && read_ready),
    .din_i   ({read_addr, read_tag}),
    .pop_i   (rd_issue),
    .dout_o  (r_head),
    .full_o  (r_full),
    .empty_o (r_empty),
    .count_o (r_count)
  );

  // Registered occupancy: a same-cycle return does not open a slot until the
  // next cycle, so the request never has a combinational path from rd_0_vld.
  assign tag_full   = (t_count == TCW'(MAX_OUTSTANDING));
  assign read_ready = !r_full;
  assign rd_0_req   = !r_empty && !tag_full;
  assign rd_0_addr  = r_head[RW-1:TAG_WIDTH];
  assign rd_issue   = rd_0_req && rd_0_ack;

  // Tag FIFO: one entry per acknowledged read awaiting its data.
  flow_ram_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tfifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rd_issue),
    .din_i   (r_head[TAG_WIDTH-1:0]),
    .pop_i   (read_data_new),
    .dout_o  (t_head),
    .full_o  (t_full_flag),
    .empty_o (t_empty),
    .count_o (t_count)
  );

  assign read_data     = rd_0_data;
  assign read_data_tag = t_head;
  assign read_data_new = rd_0_vld && !t_empty;

  // A returning word with nothing outstanding is a protocol error; latch it.
  always_comb begin
    underflow_d = underflow_q;
    if (rd_0_vld && t_empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= underflow_d;
  end

  assign read_underflow = underflow_q;

  // Occupancy of the request FIFOs and the tag FIFO full flag are not needed
  // here beyond the signals above.
  assign unused_status = ^{w_count, r_count, t_full_flag};

endmodule

// File: tb/tb_flow_ram_sram_ctrl.sv
module tb_flow_ram_sram_ctrl;

  localparam int AW = 19;
  localparam int DW = 72;
  localparam int TW = 8;
  localparam int RD = 4;
  localparam int MO = 8;

  logic          clk;
  logic          reset;
  logic          write_ready, write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_ready, read_en;
  logic [AW-1:0] read_addr;
  logic [TW-1:0] read_tag;
  logic [DW-1:0] read_data;
  logic [TW-1:0] read_data_tag;
  logic          read_data_new, read_underflow;
  logic [AW-1:0] wr_0_addr;
  logic [DW-1:0] wr_0_data;
  logic          wr_0_req, wr_0_ack;
  logic [AW-1:0] rd_0_addr;
  logic          rd_0_req, rd_0_ack;
  logic [DW-1:0] rd_0_data;
  logic          rd_0_vld;

  flow_ram_sram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .REQ_DEPTH(RD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .write_ready(write_ready), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data),
    .read_ready(read_ready), .read_en(read_en),
    .read_addr(read_addr), .read_tag(read_tag),
    .read_data(read_data), .read_data_tag(read_data_tag),
    .read_data_new(read_data_new), .read_underflow(read_underflow),
    .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data),
    .wr_0_req(wr_0_req), .wr_0_ack(wr_0_ack),
    .rd_0_addr(rd_0_addr), .rd_0_req(rd_0_req), .rd_0_ack(rd_0_ack),
    .rd_0_data(rd_0_data), .rd_0_vld(rd_0_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queues of pending work ----------------
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wreq_t;
  typedef struct packed { logic [AW-1:0] addr; logic [TW-1:0] tag;  } rreq_t;

  wreq_t         wq[$];
  rreq_t         rq[$];
  logic [TW-1:0] tq[$];
  bit            m_uf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wq.delete(); rq.delete(); tq.delete(); m_uf = 0;
    end else begin : model_step
      bit    w_acc, w_pop, r_acc, r_iss, t_pop;
      wreq_t wn;
      rreq_t rn, rh;
      w_acc = write_en && (wq.size() < RD);
      w_pop = (wq.size() > 0) && wr_0_ack;
      r_acc = read_en && (rq.size() < RD);
      r_iss = (rq.size() > 0) && (tq.size() < MO) && rd_0_ack;
      t_pop = rd_0_vld && (tq.size() > 0);
      if (rd_0_vld && tq.size() == 0) m_uf = 1;
      if (t_pop) void'(tq.pop_front());
      if (r_iss) begin rh = rq.pop_front(); tq.push_back(rh.tag); end
      if (w_pop) void'(wq.pop_front());
      if (w_acc) begin wn.addr = write_addr; wn.data = write_data; wq.push_back(wn); end
      if (r_acc) begin rn.addr = read_addr; rn.tag = read_tag; rq.push_back(rn); end
    end
  end

  // ---------------- per-cycle comparison against the model -------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("write_ready", write_ready, wq.size() < RD);
      check("wr_0_req", wr_0_req, wq.size() > 0);
      if (wq.size() > 0) begin
        check("wr_0_addr", wr_0_addr, wq[0].addr);
        check("wr_0_data", wr_0_data, wq[0].data);
      end
      check("read_ready", read_ready, rq.size() < RD);
      check("rd_0_req", rd_0_req, (rq.size() > 0) && (tq.size() < MO));
      if (rq.size() > 0) check("rd_0_addr", rd_0_addr, rq[0].addr);
      if (tq.size() > 0) check("read_data_tag", read_data_tag, tq[0]);
      check("read_data_new", read_data_new, rd_0_vld && (tq.size() > 0));
      check("read_data", read_data, rd_0_data);
      check("read_underflow", read_underflow, m_uf);
    end
  end

  // ---------------- observers for the hand-computed expectations -------------
  logic [AW-1:0] wr_seen[$];
  logic [TW-1:0] tag_seen[$];
  int            wr_req_cycles = 0;
  int            rd_ack_cnt    = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (wr_0_req) wr_req_cycles++;
      if (wr_0_req && wr_0_ack) wr_seen.push_back(wr_0_addr);
      if (rd_0_req && rd_0_ack) rd_ack_cnt++;
      if (read_data_new) tag_seen.push_back(read_data_tag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1; write_en = 0; write_addr = '0; write_data = '0;
    read_en = 0; read_addr = '0; read_tag = '0;
    wr_0_ack = 0; rd_0_ack = 0; rd_0_data = '0; rd_0_vld = 0;
    step(); step();
    chk_en = 1;
    check("rst_write_ready", write_ready, 1);
    check("rst_read_ready", read_ready, 1);
    check("rst_wr_0_req", wr_0_req, 0);
    check("rst_rd_0_req", rd_0_req, 0);
    check("rst_read_data_new", read_data_new, 0);
    check("rst_read_underflow", read_underflow, 0);
    reset = 0;
    step();

    // Four writes with the SRAM acking every cycle.
    wr_0_ack = 1;
    wr_seen.delete();
    wr_req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      write_en = 1; write_addr = AW'(32'h10 + i); write_data = DW'(32'h111 * (i + 1));
      if (i == 0) check("wr_req_before_accept", wr_0_req, 0);
      step();
      if (i == 0) check("wr_req_latency", wr_0_req, 1);
    end
    write_en = 0;
    repeat (6) step();
    check("wr_req_cycles", wr_req_cycles, 4);
    check("wr_issue_count", wr_seen.size(), 4);
    for (int i = 0; i < 4; i++) check("wr_issue_order", wr_seen[i], 32'h10 + i);

    // Five writes offered while the SRAM withholds ack: only four fit.
    wr_0_ack = 0;
    for (int i = 0; i < 5; i++) begin
      write_en = 1; write_addr = AW'(32'h20 + i); write_data = DW'(32'hABC0 + i);
      step();
      if (i == 3) check("wr_ready_after_4th", write_ready, 0);
    end
    write_en = 0;
    step();
    check("wr_fifo_fill", wq.size(), 4);
    check("wr_ready_full", write_ready, 0);
    check("wr_head_stable", wr_0_addr, 32'h20);
    wr_0_ack = 1;
    repeat (6) step();
    check("wr_drained", wr_0_req, 0);

    // Ten reads, SRAM acks always, no data returned: eight go out.
    rd_0_ack = 1;
    rd_ack_cnt = 0;
    tag_seen.delete();
    for (int i = 0; i < 10; i++) begin
      int n;
      read_en = 1; read_addr = AW'(32'h100 + i); read_tag = TW'(i);
      n = 0;
      while (!read_ready && n < 50) begin step(); n++; end
      if (n == 50) check("read_ready_timeout", 0, 1);
      step();
    end
    read_en = 0;
    repeat (10) step();
    check("rd_ack_limit", rd_ack_cnt, 8);
    check("rd_req_blocked", rd_0_req, 0);
    check("tag_head_0", read_data_tag, 0);

    // Tag FIFO full, ack high and data returning in the same cycle.
    rd_0_vld = 1; rd_0_data = DW'(72'h5A_0000_0000_0000_0000);
    #1;
    check("full_vld_new", read_data_new, 1);
    check("full_req_low", rd_0_req, 0);
    step();
    check("full_tag_advance", read_data_tag, 1);
    check("full_req_resume", rd_0_req, 1);
    check("full_next_addr", rd_0_addr, 32'h108);
    for (int k = 1; k < 8; k++) begin
      rd_0_data = DW'(32'hD000 + k);
      step();
    end
    rd_0_vld = 0;
    step();
    check("tags_returned_8", tag_seen.size(), 8);
    for (int i = 0; i < 8; i++) check("tag_order", tag_seen[i], i);
    check("rd_ack_all", rd_ack_cnt, 10);
    rd_0_vld = 1; rd_0_data = DW'(32'hBEEF);
    step(); step();
    rd_0_vld = 0;
    step();
    check("tags_returned_10", tag_seen.size(), 10);
    if (tag_seen.size() == 10) begin
      check("tag_8", tag_seen[8], 8);
      check("tag_9", tag_seen[9], 9);
    end

    // Stray return with nothing outstanding.
    rd_0_vld = 1;
    #1;
    check("stray_new_low", read_data_new, 0);
    check("uf_before", read_underflow, 0);
    step();
    rd_0_vld = 0;
    check("uf_set", read_underflow, 1);
    repeat (3) step();
    check("uf_sticky", read_underflow, 1);

    // Two reads outstanding, three queued, one write pending; then reset.
    rd_0_ack = 1;
    read_en = 1; read_addr = AW'(32'h200); read_tag = TW'(8'h20);
    step();
    read_addr = AW'(32'h201); read_tag = TW'(8'h21);
    step();
    read_en = 0;
    repeat (3) step();
    rd_0_ack = 0;
    for (int i = 0; i < 3; i++) begin
      read_en = 1; read_addr = AW'(32'h202 + i); read_tag = TW'(8'h22 + i);
      step();
    end
    read_en = 0;
    wr_0_ack = 0;
    write_en = 1; write_addr = AW'(32'h300); write_data = DW'(32'h77);
    step();
    write_en = 0;
    step();
    check("pre_rst_rd_req", rd_0_req, 1);
    check("pre_rst_wr_req", wr_0_req, 1);
    check("pre_rst_outstanding_tag", read_data_tag, 8'h20);
    check("pre_rst_rd_addr", rd_0_addr, 32'h202);
    #2;
    reset = 1;
    #1;
    check("async_rst_wr_req", wr_0_req, 0);
    check("async_rst_rd_req", rd_0_req, 0);
    check("async_rst_write_ready", write_ready, 1);
    check("async_rst_read_ready", read_ready, 1);
    check("async_rst_uf", read_underflow, 0);
    step();
    reset = 0;
    step();
    rd_0_vld = 1;
    #1;
    check("post_rst_new_low", read_data_new, 0);
    step();
    rd_0_vld = 0;
    check("post_rst_uf", read_underflow, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
